// File: rtl/color_window_stats.sv
// Per-channel YCbCr window classifier with per-frame hit statistics reported over valid/ready.
// Optional coordinate-sum accumulators are built when COLOR_STATS_CENTROID_EN is defined.
module color_window_stats #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 20,
  parameter int HL_VALUE   = 255,
  parameter int Y_MIN_DEF  = 60,
  parameter int Y_MAX_DEF  = 180,
  parameter int CB_MIN_DEF = -110,
  parameter int CB_MAX_DEF = -85,
  parameter int CR_MIN_DEF = -120,
  parameter int CR_MAX_DEF = -40,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                PCLK,
  input  logic                rst,
  input  logic                e_pix,
  input  logic [7:0]          Y,
  input  logic [7:0]          Cb,
  input  logic [7:0]          Cr,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                frame_start,
  input  logic                frame_end,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [2:0]          cfg_addr,
  input  logic [7:0]          cfg_data,
  output logic [N_CH-1:0]     hit,
  output logic [7:0]          Y_dec,
  output logic                stat_valid,
  input  logic                stat_ready,
  output logic [CH_W-1:0]     stat_ch,
  output logic [CNT_W-1:0]    stat_count,
  output logic [9:0]          stat_xmin,
  output logic [9:0]          stat_xmax,
  output logic [9:0]          stat_ymin,
  output logic [9:0]          stat_ymax,
  output logic [CNT_W+9:0]    stat_sumx,
  output logic [CNT_W+9:0]    stat_sumy,
  output logic                stat_overrun
);

  localparam int SUM_W = CNT_W + 10;
  localparam logic [7:0]      HL_B    = 8'(HL_VALUE);
  localparam logic [CH_W:0]   N_CH_L  = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_REPORT} state_t;

  state_t state, state_n;
  logic   clr_acc, acc_en, ch_adv, abort;

  logic [7:0] y_min [N_CH];
  logic [7:0] y_max [N_CH];
  logic [7:0] cb_min [N_CH];
  logic [7:0] cb_max [N_CH];
  logic [7:0] cr_min [N_CH];
  logic [7:0] cr_max [N_CH];

  logic [CNT_W-1:0] cnt  [N_CH];
  logic [9:0]       xmin [N_CH];
  logic [9:0]       xmax [N_CH];
  logic [9:0]       ymin [N_CH];
  logic [9:0]       ymax [N_CH];

  logic [N_CH-1:0] match;
  logic            ch_ok;

  // Strict bounds on both ends: an inverted or equal window can never match.
  always_comb begin
    match = '0;
    for (int c = 0; c < N_CH; c++)
      match[c] = (Y > y_min[c]) && (Y < y_max[c]) &&
                 ($signed(Cb) > $signed(cb_min[c])) && ($signed(Cb) < $signed(cb_max[c])) &&
                 ($signed(Cr) > $signed(cr_min[c])) && ($signed(Cr) < $signed(cr_max[c]));
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK) begin
    if (rst) begin
      hit   <= '0;
      Y_dec <= '0;
    end else if (e_pix) begin
      hit   <= match;
      Y_dec <= (|match) ? HL_B : Y;
    end else begin
      hit   <= '0;
    end
  end

  assign ch_ok = ({1'b0, cfg_ch} < N_CH_L);

  // NOTE: threshold registers are a handful of flops, so they get a real reset to the default windows.
  always_ff @(posedge PCLK) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        y_min[c]  <= 8'(Y_MIN_DEF);
        y_max[c]  <= 8'(Y_MAX_DEF);
        cb_min[c] <= 8'(CB_MIN_DEF);
        cb_max[c] <= 8'(CB_MAX_DEF);
        cr_min[c] <= 8'(CR_MIN_DEF);
        cr_max[c] <= 8'(CR_MAX_DEF);
      end
    end else if (cfg_we && ch_ok) begin
      case (cfg_addr)
        3'd0:    y_min[cfg_ch]  <= cfg_data;
        3'd1:    y_max[cfg_ch]  <= cfg_data;
        3'd2:    cb_min[cfg_ch] <= cfg_data;
        3'd3:    cb_max[cfg_ch] <= cfg_data;
        3'd4:    cr_min[cfg_ch] <= cfg_data;
        3'd5:    cr_max[cfg_ch] <= cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    clr_acc = 1'b0;
    acc_en  = 1'b0;
    ch_adv  = 1'b0;
    abort   = 1'b0;
    case (state)
      S_IDLE: if (frame_start) begin
        clr_acc = 1'b1;
        state_n = S_ACC;
      end
      S_ACC: begin
        if (frame_end) begin
          acc_en  = e_pix;
          state_n = S_REPORT;
        end else if (frame_start) begin
          clr_acc = 1'b1;
        end else begin
          acc_en  = e_pix;
        end
      end
      S_REPORT: begin
        if (frame_start) begin
          abort   = 1'b1;
          clr_acc = 1'b1;
          state_n = S_ACC;
        end else if (stat_ready) begin
          ch_adv = 1'b1;
          if (stat_ch == LAST_CH) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign stat_valid = (state == S_REPORT);

  always_ff @(posedge PCLK) begin
    if (rst) begin
      stat_ch      <= '0;
      stat_overrun <= 1'b0;
    end else begin
      stat_overrun <= abort;
      if (state_n != S_REPORT) stat_ch <= '0;
      else if (ch_adv)         stat_ch <= stat_ch + CH_W'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (rst || clr_acc) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt[c]  <= '0;
        xmin[c] <= 10'd1023;
        xmax[c] <= '0;
        ymin[c] <= 10'd1023;
        ymax[c] <= '0;
      end
    end else if (acc_en) begin
      for (int c = 0; c < N_CH; c++) begin
        if (match[c]) begin
          if (cnt[c] != '1) cnt[c] <= cnt[c] + CNT_W'(1);
          if (x < xmin[c]) xmin[c] <= x;
          if (x > xmax[c]) xmax[c] <= x;
          if (y < ymin[c]) ymin[c] <= y;
          if (y > ymax[c]) ymax[c] <= y;
        end
      end
    end
  end

  assign stat_count = cnt[stat_ch];
  assign stat_xmin  = xmin[stat_ch];
  assign stat_xmax  = xmax[stat_ch];
  assign stat_ymin  = ymin[stat_ch];
  assign stat_ymax  = ymax[stat_ch];

`ifdef COLOR_STATS_CENTROID_EN
  logic [SUM_W-1:0] sum_x [N_CH];
  logic [SUM_W-1:0] sum_y [N_CH];

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [9:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W-9){1'b0}}, b};
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  always_ff @(posedge PCLK) begin
    if (rst || clr_acc) begin
      for (int c = 0; c < N_CH; c++) begin
        sum_x[c] <= '0;
        sum_y[c] <= '0;
      end
    end else if (acc_en) begin
      for (int c = 0; c < N_CH; c++) begin
        if (match[c]) begin
          sum_x[c] <= sat_add(sum_x[c], x);
          sum_y[c] <= sat_add(sum_y[c], y);
        end
      end
    end
  end

  assign stat_sumx = sum_x[stat_ch];
  assign stat_sumy = sum_y[stat_ch];
`else
  assign stat_sumx = '0;
  assign stat_sumy = '0;
`endif

endmodule

// File: tb/tb_color_window_stats.sv
// Directed bench for color_window_stats: pixel path, config writes, frame statistics and report handshake.
module tb_color_window_stats;

  logic        PCLK = 1'b0;
  logic        rst, e_pix, frame_start, frame_end, cfg_we, stat_ready;
  logic [7:0]  Y, Cb, Cr, cfg_data;
  logic [9:0]  x, y;
  logic [0:0]  cfg_ch;
  logic [2:0]  cfg_addr;
  logic [1:0]  hit;
  logic [7:0]  Y_dec;
  logic        stat_valid, stat_overrun;
  logic [0:0]  stat_ch;
  logic [19:0] stat_count;
  logic [9:0]  stat_xmin, stat_xmax, stat_ymin, stat_ymax;
  logic [29:0] stat_sumx, stat_sumy;

  int n_cmp = 0;
  int n_err = 0;

  color_window_stats dut (
    .PCLK(PCLK), .rst(rst), .e_pix(e_pix), .Y(Y), .Cb(Cb), .Cr(Cr), .x(x), .y(y),
    .frame_start(frame_start), .frame_end(frame_end),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .hit(hit), .Y_dec(Y_dec), .stat_valid(stat_valid), .stat_ready(stat_ready),
    .stat_ch(stat_ch), .stat_count(stat_count),
    .stat_xmin(stat_xmin), .stat_xmax(stat_xmax), .stat_ymin(stat_ymin), .stat_ymax(stat_ymax),
    .stat_sumx(stat_sumx), .stat_sumy(stat_sumy), .stat_overrun(stat_overrun)
  );

  always #5 PCLK = ~PCLK;

  localparam logic [7:0] CB_GREEN = 8'h9C;  // -100
  localparam logic [7:0] CB_EDGE  = 8'hAB;  // -85, equal to the upper Cb bound
  localparam logic [7:0] CR_GREEN = 8'hB0;  // -80

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic pixel(input logic [7:0] py, input logic [7:0] pcb, input logic [7:0] pcr,
                       input logic [9:0] px, input logic [9:0] pyy);
    e_pix = 1'b1; Y = py; Cb = pcb; Cr = pcr; x = px; y = pyy;
    tick();
    e_pix = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [19:0] c, input logic [9:0] x0,
                            input logic [9:0] x1, input logic [9:0] y0, input logic [9:0] y1,
                            input logic [29:0] sx, input logic [29:0] sy);
    check({tag, ".count"}, 64'(stat_count), 64'(c));
    check({tag, ".xmin"},  64'(stat_xmin),  64'(x0));
    check({tag, ".xmax"},  64'(stat_xmax),  64'(x1));
    check({tag, ".ymin"},  64'(stat_ymin),  64'(y0));
    check({tag, ".ymax"},  64'(stat_ymax),  64'(y1));
`ifdef COLOR_STATS_CENTROID_EN
    check({tag, ".sumx"},  64'(stat_sumx),  64'(sx));
    check({tag, ".sumy"},  64'(stat_sumy),  64'(sy));
`else
    check({tag, ".sumx"},  64'(stat_sumx),  64'(0));
    check({tag, ".sumy"},  64'(stat_sumy),  64'(0));
    if (sx != sy) begin end
`endif
  endtask

  initial begin
    rst = 1'b1; e_pix = 1'b0; frame_start = 1'b0; frame_end = 1'b0; cfg_we = 1'b0;
    stat_ready = 1'b0; Y = '0; Cb = '0; Cr = '0; x = '0; y = '0;
    cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst.hit",     64'(hit), 64'(0));
    check("rst.Y_dec",   64'(Y_dec), 64'(0));
    check("rst.valid",   64'(stat_valid), 64'(0));
    check("rst.ch",      64'(stat_ch), 64'(0));
    check("rst.overrun", 64'(stat_overrun), 64'(0));
    check_word("rst", 20'd0, 10'd1023, 10'd0, 10'd1023, 10'd0, 30'd0, 30'd0);

    // Default windows on both channels: a green pixel hits both.
    pixel(8'd100, CB_GREEN, CR_GREEN, 10'd0, 10'd0);
    check("green.hit",   64'(hit), 64'(2'b11));
    check("green.Y_dec", 64'(Y_dec), 64'(255));
    pixel(8'd100, CB_EDGE, CR_GREEN, 10'd0, 10'd0);
    check("edge.hit",    64'(hit), 64'(2'b00));
    check("edge.Y_dec",  64'(Y_dec), 64'(100));
    pixel(8'd60, CB_GREEN, CR_GREEN, 10'd0, 10'd0);
    check("ymin_edge.hit", 64'(hit), 64'(2'b00));
    check("ymin_edge.Y_dec", 64'(Y_dec), 64'(60));
    tick();
    check("idle.hit",    64'(hit), 64'(0));
    check("idle.Y_dec",  64'(Y_dec), 64'(60));

    // Narrow channel 1 to Y < 90; an out-of-range address must not disturb anything.
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_addr = 3'd1; cfg_data = 8'd90;
    tick();
    cfg_addr = 3'd6; cfg_data = 8'd0;
    tick();
    cfg_we = 1'b0;
    pixel(8'd100, CB_GREEN, CR_GREEN, 10'd0, 10'd0);
    check("cfg.hit",     64'(hit), 64'(2'b01));
    check("cfg.Y_dec",   64'(Y_dec), 64'(255));

    // Frame 1: three ch0 hits plus a non-matching pixel at the origin.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pixel(8'd100, CB_GREEN, CR_GREEN, 10'd10, 10'd20);
    pixel(8'd100, CB_EDGE,  CR_GREEN, 10'd0,  10'd0);
    pixel(8'd100, CB_GREEN, CR_GREEN, 10'd30, 10'd5);
    pixel(8'd100, CB_GREEN, CR_GREEN, 10'd15, 10'd40);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("f1.valid", 64'(stat_valid), 64'(1));
    check("f1.ch",    64'(stat_ch), 64'(0));
    check_word("f1.ch0", 20'd3, 10'd10, 10'd30, 10'd5, 10'd40, 30'd55, 30'd65);

    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.valid", 64'(stat_valid), 64'(1));
      check("hold.ch",    64'(stat_ch), 64'(0));
      check("hold.count", 64'(stat_count), 64'(3));
      check("hold.xmax",  64'(stat_xmax), 64'(30));
    end

    stat_ready = 1'b1;
    tick();
    check("f1.ch_adv", 64'(stat_ch), 64'(1));
    check("f1.valid1", 64'(stat_valid), 64'(1));
    check_word("f1.ch1", 20'd0, 10'd1023, 10'd0, 10'd1023, 10'd0, 30'd0, 30'd0);
    tick();
    check("f1.done",   64'(stat_valid), 64'(0));
    stat_ready = 1'b0;
    tick();

    // Frame 2: the pixel on the frame_end cycle is included.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pixel(8'd100, CB_GREEN, CR_GREEN, 10'd50, 10'd60);
    frame_end = 1'b1;
    pixel(8'd100, CB_GREEN, CR_GREEN, 10'd7, 10'd100);
    frame_end = 1'b0;
    check_word("f2.ch0", 20'd2, 10'd7, 10'd50, 10'd60, 10'd100, 30'd57, 30'd160);
    stat_ready = 1'b1; tick(); stat_ready = 1'b0;
    check("f2.ch", 64'(stat_ch), 64'(1));

    // Abort the report with a new frame.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("abort.overrun", 64'(stat_overrun), 64'(1));
    check("abort.valid",   64'(stat_valid), 64'(0));
    tick();
    check("abort.pulse",   64'(stat_overrun), 64'(0));
    pixel(8'd100, CB_GREEN, CR_GREEN, 10'd200, 10'd300);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("f3.valid", 64'(stat_valid), 64'(1));
    check_word("f3.ch0", 20'd1, 10'd200, 10'd200, 10'd300, 10'd300, 30'd200, 30'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
